// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: per-source FIFOs feeding one registered write port.
// Optional feature macro: RF_ARB_X0_DROP_EN (drop writes to x0 at the handshake).

package rf_arb_pkg;
  localparam int XLEN = 32;

  typedef logic [4:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;
endpackage

module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  rv_reg_t            alu_rd,
  input  logic [XLEN-1:0]    alu_value,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  rv_reg_t            mem_rd,
  input  logic [XLEN-1:0]    mem_value,
  output reg_write_control_t write_control,
  output logic [31:0]        pending_mask,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  // Handshake: a source entry transfers on a posedge where valid && ready; ready is
  // "queue not full" from the registered count only, and the source holds rd/value
  // stable while valid is high and ready is low.

  rv_reg_t         alu_rd_q  [DEPTH];
  logic [XLEN-1:0] alu_val_q [DEPTH];
  rv_reg_t         mem_rd_q  [DEPTH];
  logic [XLEN-1:0] mem_val_q [DEPTH];

  logic [PW-1:0] alu_wr_ptr, alu_rd_ptr, mem_wr_ptr, mem_rd_ptr;
  logic [CW-1:0] alu_count, mem_count;
  logic          last_grant;

  logic alu_keep, mem_keep;
  logic alu_push, mem_push;
  logic alu_pop, mem_pop;
  logic alu_has, mem_has;

`ifdef RF_ARB_X0_DROP_EN
  assign alu_keep = (alu_rd != '0);
  assign mem_keep = (mem_rd != '0);
`else
  assign alu_keep = 1'b1;
  assign mem_keep = 1'b1;
`endif

  assign alu_ready = (alu_count != FULL);
  assign mem_ready = (mem_count != FULL);
  assign alu_push  = alu_valid && alu_ready && alu_keep;
  assign mem_push  = mem_valid && mem_ready && mem_keep;
  assign alu_has   = (alu_count != '0);
  assign mem_has   = (mem_count != '0);

  // Round-robin: on a tie the source not granted last wins.
  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    if (alu_has && mem_has) begin
      if (last_grant == GRANT_MEM) alu_pop = 1'b1;
      else                         mem_pop = 1'b1;
    end else if (alu_has) begin
      alu_pop = 1'b1;
    end else if (mem_has) begin
      mem_pop = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_wr_ptr    <= '0;
      alu_rd_ptr    <= '0;
      alu_count     <= '0;
      mem_wr_ptr    <= '0;
      mem_rd_ptr    <= '0;
      mem_count     <= '0;
      last_grant    <= GRANT_MEM;
      write_control <= '0;
    end else begin
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + PW'(1);
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PW'(1);
      if (mem_push) mem_wr_ptr <= mem_wr_ptr + PW'(1);
      if (mem_pop)  mem_rd_ptr <= mem_rd_ptr + PW'(1);
      alu_count <= alu_count + CW'(alu_push) - CW'(alu_pop);
      mem_count <= mem_count + CW'(mem_push) - CW'(mem_pop);
      if (alu_pop) begin
        write_control <= '{enable: 1'b1, which_register: alu_rd_q[alu_rd_ptr],
                           value: alu_val_q[alu_rd_ptr]};
        last_grant    <= GRANT_ALU;
      end else if (mem_pop) begin
        write_control <= '{enable: 1'b1, which_register: mem_rd_q[mem_rd_ptr],
                           value: mem_val_q[mem_rd_ptr]};
        last_grant    <= GRANT_MEM;
      end else begin
        write_control <= '0;
      end
    end
  end

  // Queue storage needs no reset; the counts define which slots are live.
  always_ff @(posedge clock) begin
    if (!reset && alu_push) begin
      alu_rd_q[alu_wr_ptr]  <= alu_rd;
      alu_val_q[alu_wr_ptr] <= alu_value;
    end
    if (!reset && mem_push) begin
      mem_rd_q[mem_wr_ptr]  <= mem_rd;
      mem_val_q[mem_wr_ptr] <= mem_value;
    end
  end

  function automatic logic [CW-1:0] slot_age(input logic [PW-1:0] slot,
                                             input logic [PW-1:0] rd_ptr);
    logic [PW-1:0] diff;
    diff = slot - rd_ptr;
    return {1'b0, diff};
  endfunction

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_age(PW'(i), alu_rd_ptr) < alu_count) pending_mask[alu_rd_q[i]] = 1'b1;
      if (slot_age(PW'(i), mem_rd_ptr) < mem_count) pending_mask[mem_rd_q[i]] = 1'b1;
    end
    if (write_control.enable) pending_mask[write_control.which_register] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign busy = alu_has || mem_has || write_control.enable;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    rv_reg_t         rd;
    logic [XLEN-1:0] value;
  } ent_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               alu_valid, mem_valid;
  logic               alu_ready, mem_ready;
  rv_reg_t            alu_rd, mem_rd;
  logic [XLEN-1:0]    alu_value, mem_value;
  reg_write_control_t write_control;
  logic [31:0]        pending_mask;
  logic               busy;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_value(mem_value),
    .write_control(write_control), .pending_mask(pending_mask), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  ent_t               aq[$];
  ent_t               mq[$];
  reg_write_control_t m_wc;
  bit                 m_last_mem;
  bit                 alu_hs, mem_hs;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] obs_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit model_keep(input rv_reg_t rd);
`ifdef RF_ARB_X0_DROP_EN
    return rd != 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] m;
    m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_wc.enable) m[m_wc.which_register] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock edge: model follows the edge, then every output is compared.
  task automatic step();
    ent_t e;
    alu_hs = !reset && alu_valid && (aq.size() < DEPTH);
    mem_hs = !reset && mem_valid && (mq.size() < DEPTH);
    @(posedge clock);
    if (reset) begin
      aq.delete();
      mq.delete();
      m_wc       = '0;
      m_last_mem = 1'b1;
    end else begin
      if (aq.size() > 0 && (mq.size() == 0 || m_last_mem)) begin
        e = aq.pop_front();
        m_wc = '{enable: 1'b1, which_register: e.rd, value: e.value};
        m_last_mem = 1'b0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wc = '{enable: 1'b1, which_register: e.rd, value: e.value};
        m_last_mem = 1'b1;
      end else begin
        m_wc = '0;
      end
      if (alu_hs && model_keep(alu_rd)) aq.push_back('{rd: alu_rd, value: alu_value});
      if (mem_hs && model_keep(mem_rd)) mq.push_back('{rd: mem_rd, value: mem_value});
    end
    #1;
    check("write_control", 64'(write_control), 64'(m_wc));
    check("alu_ready", 64'(alu_ready), 64'(aq.size() < DEPTH));
    check("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
    check("pending_mask", 64'(pending_mask), 64'(model_pending()));
    check("busy", 64'(busy), 64'(aq.size() > 0 || mq.size() > 0 || m_wc.enable));
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_value = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_value = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int  k;
    int  pulses;
    bit  saw_full, saw_b, x0_reg_ok;

    m_wc = '0;
    m_last_mem = 1'b1;
    do_reset();
    check("reset_wc", 64'(write_control), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Single uncontended ALU write: latency 2, pending bit across both cycles.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'hDEADBEEF;
    step();
    idle_inputs();
    check("lat_pending_c1", 64'(pending_mask[5]), 64'd1);
    check("lat_enable_c1", 64'(write_control.enable), 64'd0);
    step();
    check("lat_wc_c2", 64'(write_control), {26'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    check("lat_pending_c2", 64'(pending_mask[5]), 64'd1);
    step();
    check("lat_enable_c3", 64'(write_control.enable), 64'd0);
    check("lat_pending_c3", 64'(pending_mask[5]), 64'd0);

    // Tie right after reset: ALU first, MEM next.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_value = 32'h22;
    step();
    idle_inputs();
    step();
    check("tie_first_alu", 64'(write_control), {26'd0, 1'b1, 5'd3, 32'h11});
    step();
    check("tie_second_mem", 64'(write_control), {26'd0, 1'b1, 5'd4, 32'h22});
    step();
    check("tie_busy_after", 64'(busy), 64'd0);

    // MEM backpressure under saturating ALU traffic; MEM order must survive.
    do_reset();
    k = 0;
    saw_full = 1'b0;
    alu_hs = 1'b1;
    for (int i = 0; i < 30; i++) begin
      alu_valid = 1'b1;
      if (alu_hs) begin
        alu_rd    = rv_reg_t'($urandom_range(1, 31));
        alu_value = $urandom & 32'h0FFF_FFFF;
      end
      mem_valid = (k < 4);
      mem_rd    = rv_reg_t'(10 + k);
      mem_value = 32'hA000_0000 | 32'(k);
      step();
      if (mem_hs) begin
        exp_q.push_back(mem_value);
        k++;
      end
      if (!mem_ready) saw_full = 1'b1;
      if (write_control.enable && write_control.value[31:28] == 4'hA)
        obs_q.push_back(write_control.value);
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      step();
      if (write_control.enable && write_control.value[31:28] == 4'hA)
        obs_q.push_back(write_control.value);
    end
    check("bp_mem_ready_low", 64'(saw_full), 64'd1);
    check("bp_accepted", 64'(exp_q.size()), 64'd4);
    check("bp_written", 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("bp_order", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));

    // Reset with both queues loaded and a write in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = rv_reg_t'(20 + i); alu_value = 32'hB000_0000 | 32'(i);
      mem_valid = 1'b1; mem_rd = rv_reg_t'(24 + i); mem_value = 32'hB100_0000 | 32'(i);
      step();
    end
    check("mid_enable_before", 64'(write_control.enable), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    check("mid_wc", 64'(write_control), 64'd0);
    check("mid_alu_ready", 64'(alu_ready), 64'd1);
    check("mid_mem_ready", 64'(mem_ready), 64'd1);
    check("mid_pending", 64'(pending_mask), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    saw_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (write_control.enable) saw_b = 1'b1;
    end
    check("mid_no_stale_write", 64'(saw_b), 64'd0);

    // Write to x0.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'h55;
    step();
    check("x0_handshake", 64'(alu_hs), 64'd1);
    idle_inputs();
    pulses = 0;
    x0_reg_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (write_control.enable) begin
        pulses++;
        if (write_control.which_register != 0 || write_control.value != 32'h55) x0_reg_ok = 1'b0;
      end
    end
`ifdef RF_ARB_X0_DROP_EN
    check("x0_pulses", 64'(pulses), 64'd0);
`else
    check("x0_pulses", 64'(pulses), 64'd1);
`endif
    check("x0_fields", 64'(x0_reg_ok), 64'd1);

    // Random traffic; payload is held while valid waits for ready.
    do_reset();
    alu_hs = 1'b1;
    mem_hs = 1'b1;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (alu_hs || !alu_valid) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = rv_reg_t'($urandom_range(0, 31));
        alu_value = $urandom;
      end
      if (mem_hs || !mem_valid) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = rv_reg_t'($urandom_range(0, 31));
        mem_value = $urandom;
      end
      step();
      if (reset) begin
        alu_hs = 1'b1;
        mem_hs = 1'b1;
      end
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    check("drain_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-source queue depth in entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port alu_valid  input  1  ALU writeback request present.
REQ-005 SHALL have port alu_ready  output  1  ALU queue can accept this cycle.
REQ-006 SHALL have ports alu_rd  input  rv_reg_t and alu_value  input  XLEN  ALU destination register and result.
REQ-007 SHALL have port mem_valid  input  1  load-unit writeback request present.
REQ-008 SHALL have port mem_ready  output  1  load queue can accept this cycle.
REQ-009 SHALL have ports mem_rd  input  rv_reg_t and mem_value  input  XLEN  load destination register and data.
REQ-010 SHALL have port write_control  output  reg_write_control_t  registered drive of the single register-file write port.
REQ-011 SHALL have port pending_mask  output  32  bit r set while a write to xr is queued or on write_control.
REQ-012 SHALL have port busy  output  1  any queue non-empty or write_control.enable high.

Function
REQ-013 SHALL hold one FIFO of DEPTH entries {rd, value} per source; in-source order SHALL be preserved.
REQ-014 SHALL accept an entry on a posedge where valid && ready; ready SHALL equal "queue not full", taken from registered count only (no same-cycle pop bypass).
REQ-015 SHALL, each posedge with at least one non-empty queue, pop exactly one head and register it onto write_control with enable=1; otherwise register enable=0.
REQ-016 SHALL arbitrate round-robin: a 1-bit last_grant register; when both heads are present the source not granted last SHALL win; last_grant updates only on a grant.
REQ-017 SHALL hold write_control.enable for exactly one cycle per popped entry; which_register and value SHALL equal the popped entry.
REQ-018 SHALL give latency 2: entry accepted at edge N appears on write_control in the cycle after edge N+1 when uncontended.
REQ-019 SHALL not pop an entry in the same edge it is pushed into an empty queue.
REQ-020 SHALL, under continuous contention, sustain one write per cycle alternating ALU/MEM; neither source SHALL wait more than one grant.
REQ-021 SHALL compute pending_mask combinationally from queue contents and write_control; bit 0 SHALL always be 0.
REQ-022 SHALL leave cross-source ordering to issue logic, which uses pending_mask; the block SHALL NOT reorder or merge same-rd entries.
REQ-023 SHALL use count registers of width clog2(DEPTH)+1 and wrapping read/write pointers of width clog2(DEPTH).

Reset
REQ-024 SHALL, while reset is high at a posedge, empty both queues, set write_control.enable=0, which_register=0, value=0, last_grant=MEM (ALU wins first tie).
REQ-025 SHALL discard in-flight entries on reset mid-operation; alu_ready and mem_ready SHALL be 1 the cycle after reset deasserts; pending_mask and busy SHALL be 0.
REQ-026 SHALL ignore valid inputs on a reset edge.

Configuration
REQ-027 SHALL honour macro RF_ARB_X0_DROP_EN: when defined, handshakes with rd==0 complete (ready unchanged) but the entry is not queued and never reaches write_control.
REQ-028 SHALL, without RF_ARB_X0_DROP_EN, queue and issue rd==0 entries normally with which_register=0, consuming a write slot.

Verification
REQ-029 SHALL cover: ALU push rd=5, value=0xDEADBEEF at edge 1, MEM idle -> write_control {1,5,0xDEADBEEF} in cycle after edge 2 only; pending_mask[5] high cycles 1-2.
REQ-030 SHALL cover: ALU rd=3/0x11 and MEM rd=4/0x22 pushed same edge after reset -> ALU write first, MEM next cycle, busy low afterwards.
REQ-031 SHALL cover: DEPTH=2, MEM valid 4 cycles with no drain possible (ALU saturating, alternating) -> mem_ready low when count=2; no entry lost; all 4 values written in order.
REQ-032 SHALL cover: reset asserted with 2 entries per queue and enable high -> next cycle enable=0, ready=1, pending_mask=0; pre-reset entries never written.
REQ-033 SHALL cover: ALU push rd=0/0x55 -> with RF_ARB_X0_DROP_EN no write_control.enable pulse and busy stays 0; without it one pulse with which_register=0.
